calibration_sequencer: RTL and testbench



---
 rtl/calibration_pkg.sv | 21 ++
 rtl/fb_sweep_pipe.sv | 77 +++++++
 rtl/calibration_sequencer.sv | 179 +++++++++++++++++
 tb/tb_calibration_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calibration_pkg.sv
// Shared types and sizing helpers for calibration_sequencer and calibration_manager.
package calibration_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DISPLAY,
        WAIT_SETTLE,
        SWEEP,
        DRAIN,
        ADVANCE,
        DONE
    } cal_seq_state_t;

    // Pixel intensity above which calibration_manager treats an LED as lit.
    localparam logic [15:0] CAL_PIXEL_THRESHOLD = 16'd200;

    function automatic int unsigned cal_table_counter_width(input int unsigned pixels);
        return (pixels > 1) ? $clog2(pixels) : 1;
    endfunction

endpackage

// File: rtl/fb_sweep_pipe.sv
// Frame-buffer sweep: pixel address counter, read-latency delay line and
// output register aligning address with returned pixel data.
module fb_sweep_pipe #(
    parameter int unsigned NUM_PIXELS   = 8,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned AW           = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sweep_en,
    input  logic          squash,
    input  logic [15:0]   fb_read_data,
    output logic [AW-1:0] fb_read_addr,
    output logic          last_c,
    output logic [AW-1:0] out_addr,
    output logic [15:0]   out_data,
    output logic          out_valid
);

    logic [AW-1:0]           pix_q, pix_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [AW-1:0]           addr_q [READ_LATENCY];
    logic [AW-1:0]           addr_d [READ_LATENCY];
    logic [AW-1:0]           out_addr_q, out_addr_d;
    logic [15:0]             out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;

    assign last_c       = sweep_en && (pix_q == AW'(NUM_PIXELS - 1));
    assign fb_read_addr = pix_q;
    assign out_addr     = out_addr_q;
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;

    // Counter parks at 0 outside a sweep, so it never runs past the last pixel.
    always_comb begin
        pix_d     = (sweep_en && !last_c && !squash) ? pix_q + AW'(1) : '0;
        vld_d[0]  = sweep_en;
        addr_d[0] = pix_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            addr_d[i] = addr_q[i-1];
        end
        if (squash) begin
            vld_d = '0;
        end
        out_valid_d = vld_q[READ_LATENCY-1] && !squash;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        if (vld_q[READ_LATENCY-1]) begin
            out_addr_d = addr_q[READ_LATENCY-1];
            out_data_d = fb_read_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q       <= '0;
            vld_q       <= '0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            pix_q       <= pix_d;
            vld_q       <= vld_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            for (int i = 0; i < READ_LATENCY; i++) begin
                addr_q[i] <= addr_d[i];
            end
        end
    end

endmodule

// File: rtl/calibration_sequencer.sv
// Drives the bit-serial LED identification sweep feeding calibration_manager.
// Optional watchdog on the display/settle waits: define CAL_SEQ_TIMEOUT_EN.
module calibration_sequencer
    import calibration_pkg::*;
#(
    parameter int unsigned NUM_LEDS                = 50,
    parameter int unsigned NUM_FRAME_BUFFER_PIXELS = 360*180,
    parameter int unsigned SETTLE_FRAMES           = 2,
    parameter int unsigned FB_READ_LATENCY         = 2,
`ifdef CAL_SEQ_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES          = 2**24,
`endif
    localparam int unsigned LED_ADDRESS_WIDTH       = $clog2(NUM_LEDS),
    localparam int unsigned CAL_TABLE_COUNTER_WIDTH = cal_table_counter_width(NUM_FRAME_BUFFER_PIXELS)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic                               displayed_frame_valid,
    input  logic                               camera_frame_done,
    output logic [CAL_TABLE_COUNTER_WIDTH-1:0] fb_read_addr,
    input  logic [15:0]                        fb_read_data,
    output logic                               increment_id,
    output logic                               calibration_on,
    output logic [CAL_TABLE_COUNTER_WIDTH-1:0] frame_buffer_in_address,
    output logic [15:0]                        frame_buffer_data,
    output logic                               use_this_frame_address_and_data,
    output logic                               busy,
    output logic                               done,
`ifdef CAL_SEQ_TIMEOUT_EN
    output logic                               timeout_err,
`endif
    output logic [LED_ADDRESS_WIDTH:0]         bit_index
);

    localparam int unsigned NUM_BITS     = LED_ADDRESS_WIDTH + 1;
    localparam int unsigned BW           = LED_ADDRESS_WIDTH + 1;
    localparam int unsigned SCW          = $clog2(SETTLE_FRAMES + 1);
    localparam int unsigned DRAIN_CYCLES = FB_READ_LATENCY + 3;
    localparam int unsigned DCW          = $clog2(DRAIN_CYCLES + 1);

    cal_seq_state_t state_q, state_d;
    logic [SCW-1:0] settle_q, settle_d;
    logic [DCW-1:0] drain_q, drain_d;
    logic [BW-1:0]  bit_index_q, bit_index_d;
    logic           busy_q, busy_d, cal_on_q, cal_on_d;
    logic           inc_q, inc_d, done_q, done_d;
    logic           abort_now, sweep_en, sweep_last;

`ifdef CAL_SEQ_TIMEOUT_EN
    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd_q, wd_d;
    logic           timeout_err_q, timeout_err_d;
    logic           in_wait, wd_expired;

    assign in_wait     = (state_q == WAIT_DISPLAY) || (state_q == WAIT_SETTLE);
    assign wd_expired  = in_wait && (wd_q == WDW'(TIMEOUT_CYCLES - 1));
    assign abort_now   = (abort || wd_expired) && (state_q != IDLE);
    assign timeout_err = timeout_err_q;

    // Watchdog restarts on every state change; sticky error cleared by an accepted start.
    always_comb begin
        wd_d          = (in_wait && state_d == state_q) ? wd_q + WDW'(1) : '0;
        timeout_err_d = timeout_err_q;
        if (wd_expired) begin
            timeout_err_d = 1'b1;
        end else if (state_q == IDLE && start && !abort) begin
            timeout_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
        end
    end
`else
    assign abort_now = abort && (state_q != IDLE);
`endif

    assign sweep_en = (state_q == SWEEP);

    fb_sweep_pipe #(
        .NUM_PIXELS   (NUM_FRAME_BUFFER_PIXELS),
        .READ_LATENCY (FB_READ_LATENCY),
        .AW           (CAL_TABLE_COUNTER_WIDTH)
    ) u_sweep_pipe (
        .clk          (clk),
        .rst_n        (rst_n),
        .sweep_en     (sweep_en),
        .squash       (abort_now),
        .fb_read_data (fb_read_data),
        .fb_read_addr (fb_read_addr),
        .last_c       (sweep_last),
        .out_addr     (frame_buffer_in_address),
        .out_data     (frame_buffer_data),
        .out_valid    (use_this_frame_address_and_data)
    );

    // Next state; outputs are registered from the state being entered.
    always_comb begin
        state_d     = state_q;
        bit_index_d = bit_index_q;
        settle_d    = '0;
        drain_d     = '0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d     = WAIT_DISPLAY;
                    bit_index_d = '0;
                end
            end
            WAIT_DISPLAY: begin
                if (displayed_frame_valid) state_d = WAIT_SETTLE;
            end
            WAIT_SETTLE: begin
                settle_d = settle_q + SCW'(camera_frame_done);
                if (camera_frame_done && settle_q == SCW'(SETTLE_FRAMES - 1)) state_d = SWEEP;
            end
            SWEEP: begin
                if (sweep_last) state_d = DRAIN;
            end
            DRAIN: begin
                drain_d = drain_q + DCW'(1);
                if (drain_q == DCW'(DRAIN_CYCLES - 1)) state_d = ADVANCE;
            end
            ADVANCE: begin
                if (bit_index_q == BW'(NUM_BITS - 1)) begin
                    state_d = DONE;
                end else begin
                    bit_index_d = bit_index_q + BW'(1);
                    state_d     = WAIT_DISPLAY;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_now) state_d = IDLE;
        if (state_d == IDLE) bit_index_d = '0;
        busy_d   = (state_d != IDLE);
        cal_on_d = (state_d != IDLE) && (state_d != DONE);
        inc_d    = (state_d == ADVANCE);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            drain_q     <= '0;
            bit_index_q <= '0;
            busy_q      <= 1'b0;
            cal_on_q    <= 1'b0;
            inc_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            drain_q     <= drain_d;
            bit_index_q <= bit_index_d;
            busy_q      <= busy_d;
            cal_on_q    <= cal_on_d;
            inc_q       <= inc_d;
            done_q      <= done_d;
        end
    end

    assign busy           = busy_q;
    assign calibration_on = cal_on_q;
    assign increment_id   = inc_q;
    assign done           = done_q;
    assign bit_index      = bit_index_q;

endmodule

// File: tb/tb_calibration_sequencer.sv
// Directed bench for calibration_sequencer with a 2-cycle frame-buffer model
// returning addr+0x100; also covers the CAL_SEQ_TIMEOUT_EN watchdog when defined.
`timescale 1ns/1ps
module tb_calibration_sequencer;

    localparam int unsigned NV = 13;

    logic        clk;
    logic        rst_n;
    logic        start, abort, dfv, cfd;
    logic [2:0]  fb_read_addr;
    logic [15:0] fb_read_data;
    logic        increment_id, calibration_on, use_this, busy, done;
    logic [2:0]  ia;
    logic [15:0] fdata;
    logic [3:0]  bit_index;
`ifdef CAL_SEQ_TIMEOUT_EN
    logic        timeout_err;
`endif

    calibration_sequencer #(
        .NUM_LEDS                (5),
        .NUM_FRAME_BUFFER_PIXELS (8),
        .SETTLE_FRAMES           (1),
`ifdef CAL_SEQ_TIMEOUT_EN
        .TIMEOUT_CYCLES          (100),
`endif
        .FB_READ_LATENCY         (2)
    ) dut (
        .clk                             (clk),
        .rst_n                           (rst_n),
        .start                           (start),
        .abort                           (abort),
        .displayed_frame_valid           (dfv),
        .camera_frame_done               (cfd),
        .fb_read_addr                    (fb_read_addr),
        .fb_read_data                    (fb_read_data),
        .increment_id                    (increment_id),
        .calibration_on                  (calibration_on),
        .frame_buffer_in_address         (ia),
        .frame_buffer_data               (fdata),
        .use_this_frame_address_and_data (use_this),
        .busy                            (busy),
        .done                            (done),
`ifdef CAL_SEQ_TIMEOUT_EN
        .timeout_err                     (timeout_err),
`endif
        .bit_index                       (bit_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-buffer model: data for an address appears two cycles later.
    logic [2:0] fb_a1, fb_a2;
    always_ff @(posedge clk) begin
        fb_a1 <= fb_read_addr;
        fb_a2 <= fb_a1;
    end
    assign fb_read_data = 16'h0100 + 16'(fb_a2);

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [3:0]  in;      // start, abort, displayed_frame_valid, camera_frame_done
        logic [3:0]  ctl;     // busy, calibration_on, increment_id, done
        logic [3:0]  bit_idx;
        logic [2:0]  addr;
        logic        vld;
        logic [2:0]  ia;
        logic [15:0] data;
    } vec_t;

    vec_t vecs [NV];

    int exp_addr, beats, incs, dones, first, tk;
    int extra_done, extra_busy, post_beats;
    logic finished;

    initial begin
        // start+abort in IDLE, start, start while busy, dfv with coincident frame pulse,
        // settle pulse, sweep with aligned beats, then abort and squash.
        vecs[0]  = '{4'b1100, 4'b0000, 4'd0, 3'd0, 1'b0, 3'd0, 16'h0000};
        vecs[1]  = '{4'b1000, 4'b1100, 4'd0, 3'd0, 1'b0, 3'd0, 16'h0000};
        vecs[2]  = '{4'b1000, 4'b1100, 4'd0, 3'd0, 1'b0, 3'd0, 16'h0000};
        vecs[3]  = '{4'b0011, 4'b1100, 4'd0, 3'd0, 1'b0, 3'd0, 16'h0000};
        vecs[4]  = '{4'b0010, 4'b1100, 4'd0, 3'd0, 1'b0, 3'd0, 16'h0000};
        vecs[5]  = '{4'b0011, 4'b1100, 4'd0, 3'd0, 1'b0, 3'd0, 16'h0000};
        vecs[6]  = '{4'b0010, 4'b1100, 4'd0, 3'd1, 1'b0, 3'd0, 16'h0000};
        vecs[7]  = '{4'b0010, 4'b1100, 4'd0, 3'd2, 1'b0, 3'd0, 16'h0000};
        vecs[8]  = '{4'b0010, 4'b1100, 4'd0, 3'd3, 1'b1, 3'd0, 16'h0100};
        vecs[9]  = '{4'b0010, 4'b1100, 4'd0, 3'd4, 1'b1, 3'd1, 16'h0101};
        vecs[10] = '{4'b0010, 4'b1100, 4'd0, 3'd5, 1'b1, 3'd2, 16'h0102};
        vecs[11] = '{4'b0100, 4'b0000, 4'd0, 3'd0, 1'b0, 3'd0, 16'h0000};
        vecs[12] = '{4'b0010, 4'b0000, 4'd0, 3'd0, 1'b0, 3'd0, 16'h0000};

        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; dfv = 1'b0; cfd = 1'b0;
        #22;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_calon", 32'(calibration_on), 32'd0);
        chk("reset_valid", 32'(use_this), 32'd0);
        chk("reset_bit", 32'(bit_index), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < int'(NV); i++) begin
            {start, abort, dfv, cfd} = vecs[i].in;
            step();
            chk($sformatf("vec%0d_ctl", i), 32'({busy, calibration_on, increment_id, done}), 32'(vecs[i].ctl));
            chk($sformatf("vec%0d_bit", i), 32'(bit_index), 32'(vecs[i].bit_idx));
            chk($sformatf("vec%0d_fbaddr", i), 32'(fb_read_addr), 32'(vecs[i].addr));
            chk($sformatf("vec%0d_valid", i), 32'(use_this), 32'(vecs[i].vld));
            if (vecs[i].vld) begin
                chk($sformatf("vec%0d_addr", i), 32'(ia), 32'(vecs[i].ia));
                chk($sformatf("vec%0d_data", i), 32'(fdata), 32'(vecs[i].data));
            end
        end
        {start, abort, dfv, cfd} = 4'b0000;

        // Nothing may trickle out after the abort.
        post_beats = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (use_this || increment_id || done || busy) post_beats++;
        end
        chk("abort_quiet", 32'(post_beats), 32'd0);

        // Full calibration run.
        dfv = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        exp_addr = 0; beats = 0; incs = 0; dones = 0; finished = 1'b0;
        for (int k = 1; k < 2000 && !finished; k++) begin
            cfd = (k % 20 == 0);
            step();
            if (use_this) begin
                chk("run_addr", 32'(ia), 32'(exp_addr));
                chk("run_data", 32'(fdata), 32'(exp_addr + 32'h100));
                exp_addr++;
                beats++;
            end
            if (increment_id) begin
                chk("run_beats", 32'(beats), 32'd8);
                chk("run_bit", 32'(bit_index), 32'(incs));
                incs++;
                beats = 0;
                exp_addr = 0;
            end
            if (done) begin
                finished = 1'b1;
                chk("done_calon", 32'(calibration_on), 32'd0);
            end else begin
                chk("run_calon", 32'(calibration_on), 32'd1);
            end
        end
        cfd = 1'b0;
        chk("run_finished", 32'(finished), 32'd1);
        chk("run_incs", 32'(incs), 32'd4);
        extra_done = 0; extra_busy = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (done) extra_done++;
            if (busy || calibration_on || use_this) extra_busy++;
        end
        chk("done_once", 32'(extra_done), 32'd0);
        chk("idle_after_done", 32'(extra_busy), 32'd0);

        // Settle: display valid late, first beat only after the frame pulse at 60.
        dfv = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        first = 0;
        for (int k = 1; k <= 70; k++) begin
            dfv = (k >= 50);
            cfd = (k == 60);
            step();
            if (use_this && first == 0) first = k;
        end
        chk("settle_first_beat", 32'(first), 32'd63);
        dfv = 1'b0; cfd = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("settle_abort_busy", 32'(busy), 32'd0);

        // Asynchronous reset while waiting to settle.
        start = 1'b1;
        step();
        start = 1'b0;
        dfv = 1'b1;
        step();
        dfv = 1'b0;
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outs", 32'({busy, calibration_on, increment_id, done, use_this}), 32'd0);
        chk("async_reset_bit", 32'(bit_index), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_reset_busy", 32'(busy), 32'd0);

`ifdef CAL_SEQ_TIMEOUT_EN
        chk("to_initial", 32'(timeout_err), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        tk = 0;
        for (int k = 1; k <= 300 && tk == 0; k++) begin
            step();
            if (timeout_err) tk = k;
        end
        chk("to_cycle", 32'(tk), 32'd100);
        chk("to_idle", 32'({busy, calibration_on}), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("to_cleared", 32'(timeout_err), 32'd0);
        chk("to_restart_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
